// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the EXE-stage iterative multiply/divide unit.
//   op encodings : OP_MULTU / OP_MULT / OP_DIVU / OP_DIV  (op[1]=divide, op[0]=signed)
//   state_t      : IDLE / CALC / FIX
//   ITER         : number of CALC iterations (one result bit per edge)
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/exe_muldiv_if.sv
// Handshake/result bundle between the EXE stage and the mul/div unit.
//   start, op, a, b, flush : issued by the pipeline (master)
//   busy, stall, done      : unit status back to the pipeline
//   hi, lo                 : architectural HI/LO registers
interface exe_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/exe_muldiv_sign.sv
// Combinational conditional two's-complement negate.
//   neg : 1 = output -x, 0 = output x
//   x   : W-bit input
//   y   : W-bit result
// Used both for taking operand magnitudes and for result sign correction.
module exe_muldiv_sign #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = neg ? ((~x) + W'(1)) : x;
endmodule

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk, clrn : clock (rising edge), asynchronous active-low reset
//   bus       : slave side of exe_muldiv_if (start/op/a/b/flush in,
//               busy/stall/done/hi/lo out)
// Multiply is 32-step shift-add on magnitudes; divide is 32-step restoring.
// Signs are captured at start and applied in FIX.
module exe_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          clrn,
    exe_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic               b_zero;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Magnitudes are held as unsigned WIDTH-bit values, so |0x80000000|
    // is representable; the extra bit lives in the adder/subtractor below.
    exe_muldiv_sign #(.W(WIDTH)) u_abs_a (
        .neg(bus.op[0] & bus.a[WIDTH-1]), .x(bus.a), .y(abs_a));
    exe_muldiv_sign #(.W(WIDTH)) u_abs_b (
        .neg(bus.op[0] & bus.b[WIDTH-1]), .x(bus.b), .y(abs_b));
    exe_muldiv_sign #(.W(2*WIDTH)) u_fix_prod (
        .neg(neg_a ^ neg_b), .x({acc_hi, acc_lo}), .y(prod_fix));
    exe_muldiv_sign #(.W(WIDTH)) u_fix_quo (
        .neg(neg_a ^ neg_b), .x(acc_lo), .y(quo_fix));
    exe_muldiv_sign #(.W(WIDTH)) u_fix_rem (
        .neg(neg_a), .x(acc_hi), .y(rem_fix));

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mb};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            mb     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            is_div <= bus.op[1];
                            neg_a  <= bus.op[0] & bus.a[WIDTH-1];
                            neg_b  <= bus.op[0] & bus.b[WIDTH-1];
                            b_zero <= (bus.b == '0);
                            mb     <= abs_b;
                            acc_hi <= '0;
                            acc_lo <= abs_a;
                            cnt    <= '0;
                            state  <= CALC;
                        end
                    end
                    CALC: begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            // Remainder never exceeds WIDTH bits, so dropping
                            // the top bit of the difference/shift is safe.
                            if (!div_diff[WIDTH+1]) begin
                                acc_hi <= div_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        if (is_div) begin
                            // Divide by zero: remainder naturally equals the
                            // original dividend; quotient forced to all ones.
                            hi_q <= rem_fix;
                            lo_q <= b_zero ? '1 : quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.stall = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: stimulus pushes expected {hi,lo},
// a negedge monitor pops and compares whenever done is presented.
module tb_exe_muldiv;
    import muldiv_pkg::*;

    logic clk;
    logic clrn;
    int   n_total;
    int   n_pass;
    logic [63:0] exp_q[$];

    exe_muldiv_if #(.WIDTH(32)) bus ();

    exe_muldiv #(.WIDTH(32)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        else
            n_pass++;
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: actual=done with empty queue required=no done (hi=%h lo=%h)",
                         bus.hi, bus.lo);
            end else begin
                chk("result_hi_lo", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    // Issue one op; intf>0 injects a conflicting start in that busy cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input int intf);
        int   cyc;
        logic seen;
        logic busy_ok;
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
            if (bus.stall !== bus.busy) busy_ok = 1'b0;
            bus.start = (cyc == intf);
            if (cyc == intf) begin
                bus.op = OP_DIVU;
                bus.a  = 32'd123;
                bus.b  = 32'd456;
            end
        end
        bus.start = 1'b0;
        chk("latency", 64'(cyc), 64'd34);
        chk("busy_window", {63'd0, busy_ok}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_total   = 0;
        n_pass    = 0;
        clrn      = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0);
        run_op(OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 0);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 0);
        run_op(OP_DIVU,  32'd100,      32'd0,        64'h00000064_FFFFFFFF, 0);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, 0);
        run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 0);
        run_op(OP_DIVU,  32'hFFFFFFFF, 32'd16,       64'h0000000F_0FFFFFFF, 0);
        run_op(OP_MULTU, 32'd6,        32'd7,        64'h00000000_0000002A, 0);

        // Flush mid-divide: no done, HI/LO untouched.
        @(negedge clk);
        bus.op    = OP_DIVU;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hi_lo", {bus.hi, bus.lo}, 64'h00000000_0000002A);

        // Start while busy is ignored.
        run_op(OP_MULT, 32'd5, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFEC, 5);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.op    = OP_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("async_rst_done", {63'd0, bus.done}, 64'd0);
        chk("async_rst_hi_lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (40) @(negedge clk);
        run_op(OP_DIVU, 32'd9, 32'd2, 64'h00000001_00000004, 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
